// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter slice.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents: FSM state enum, command field widths, bit-count validity helper.
package spi_arb_pkg;

  localparam int DATA_W   = 32;  // SPI word width
  localparam int BITCNT_W = 6;   // transfer length field width
  localparam int DIV_W    = 16;  // SCLK divider field width
  localparam int MAX_BITS = 32;  // longest legal transfer
  localparam int GAP_W    = 4;   // wide enough for CS_GAP up to 15

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RESPOND   = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_t;

  // A transfer length is usable only if it is 1..MAX_BITS.
  function automatic logic bit_count_ok(input logic [BITCNT_W-1:0] bc);
    return (bc != '0) && (bc <= BITCNT_W'(MAX_BITS));
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until the owner's rsp_valid pulse.
//
// Ports (slave = arbiter view):
//   in : req, req_tx_data, req_bit_count, req_clk_div, req_cpol, req_cpha,
//        m_busy, m_done, m_cs, m_rx_data
//   out: gnt, rsp_valid, rsp_data, rsp_err, m_start, m_tx_data, m_bit_count,
//        m_clk_div, m_cpol, m_cpha, cs_n
interface spi_arbiter_if #(
  parameter int N_REQ = 4
);
  import spi_arb_pkg::*;

  // Requester side (packed per requester, slice i at [W*i +: W])
  logic [N_REQ-1:0]          req;
  logic [DATA_W*N_REQ-1:0]   req_tx_data;
  logic [BITCNT_W*N_REQ-1:0] req_bit_count;
  logic [DIV_W*N_REQ-1:0]    req_clk_div;
  logic [N_REQ-1:0]          req_cpol;
  logic [N_REQ-1:0]          req_cpha;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  // SPI master command / status
  logic                      m_start;
  logic [DATA_W-1:0]         m_tx_data;
  logic [BITCNT_W-1:0]       m_bit_count;
  logic [DIV_W-1:0]          m_clk_div;
  logic                      m_cpol;
  logic                      m_cpha;
  logic                      m_busy;
  logic                      m_done;
  logic                      m_cs;
  logic [DATA_W-1:0]         m_rx_data;

  // Per-device chip selects, active-low
  logic [N_REQ-1:0]          cs_n;

  modport slave (
    input  req, req_tx_data, req_bit_count, req_clk_div, req_cpol, req_cpha,
    input  m_busy, m_done, m_cs, m_rx_data,
    output gnt, rsp_valid, rsp_data, rsp_err,
    output m_start, m_tx_data, m_bit_count, m_clk_div, m_cpol, m_cpha,
    output cs_n
  );

  modport master (
    output req, req_tx_data, req_bit_count, req_clk_div, req_cpol, req_cpha,
    output m_busy, m_done, m_cs, m_rx_data,
    input  gnt, rsp_valid, rsp_data, rsp_err,
    input  m_start, m_tx_data, m_bit_count, m_clk_div, m_cpol, m_cpha,
    input  cs_n
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Round-robin selector: first live request at or above i_ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; o_gnt is all-zero when no request is live.
//
// Ports: i_req (request levels), i_ptr (search start index),
//        o_gnt (one-hot winner), o_idx (winner index, 0 when none).
module spi_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic w_found;

  // Index ptr+k folded back into 0..N_REQ-1; ptr is always < N_REQ.
  function automatic logic [IDX_W-1:0] wrap_idx(input int a);
    return (a >= N_REQ) ? IDX_W'(a - N_REQ) : IDX_W'(a);
  endfunction

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req[wrap_idx(int'(i_ptr) + k)]) begin
        w_found                            = 1'b1;
        o_gnt[wrap_idx(int'(i_ptr) + k)]   = 1'b1;
        o_idx                              = wrap_idx(int'(i_ptr) + k);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among N_REQ requesters with round-robin arbitration.
// Latency: pick -> m_start 1 cycle; m_done -> rsp_valid 1 cycle; CS_GAP idle cycles after each response.
// Backpressure: no pick while m_busy is high or during the gap; requests wait as held levels.
//
// Ports: clk, rst (async, active-high), arb (spi_arbiter_if.slave: requester
//        levels/config in, gnt/rsp out, SPI master command out/status in, cs_n out).
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int CS_GAP = 2
) (
  input logic          clk,
  input logic          rst,
  spi_arbiter_if.slave arb
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Last count value in GAP; unused when CS_GAP is 0 because GAP is never entered.
  localparam logic [GAP_W-1:0] GAP_LAST = (CS_GAP > 0) ? GAP_W'(CS_GAP - 1) : '0;

  // ---------------------------------------------------------------- state
  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_owner;
  logic                 r_err;
  logic [GAP_W-1:0]     r_gap_cnt;

  logic [DATA_W-1:0]    r_m_tx;
  logic [BITCNT_W-1:0]  r_m_bc;
  logic [DIV_W-1:0]     r_m_div;
  logic                 r_m_cpol;
  logic                 r_m_cpha;

  // ---------------------------------------------------------------- arbitration
  logic [N_REQ-1:0]     w_rr_gnt;
  logic [IDX_W-1:0]     w_rr_idx;
  logic                 w_pick;

  logic [DATA_W-1:0]    w_sel_tx;
  logic [BITCNT_W-1:0]  w_sel_bc;
  logic [DIV_W-1:0]     w_sel_div;
  logic                 w_sel_cpol;
  logic                 w_sel_cpha;
  logic                 w_sel_bc_ok;

  logic [N_REQ-1:0]     w_owner_oh;

  // Combinational outputs
  logic [N_REQ-1:0]     w_gnt;
  logic [N_REQ-1:0]     w_rsp_vld;
  logic [DATA_W-1:0]    w_rsp_dat;
  logic                 w_rsp_err;
  logic                 w_m_start;
  logic [N_REQ-1:0]     w_cs_n;

  spi_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req (arb.req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx)
  );

  // A pick happens only from IDLE with the master free.
  assign w_pick = (r_state == ST_IDLE) && (|w_rr_gnt) && !arb.m_busy;

  // Winner's command fields, taken straight from its packed slices.
  assign w_sel_tx    = arb.req_tx_data  [int'(w_rr_idx)*DATA_W   +: DATA_W];
  assign w_sel_bc    = arb.req_bit_count[int'(w_rr_idx)*BITCNT_W +: BITCNT_W];
  assign w_sel_div   = arb.req_clk_div  [int'(w_rr_idx)*DIV_W    +: DIV_W];
  assign w_sel_cpol  = arb.req_cpol[w_rr_idx];
  assign w_sel_cpha  = arb.req_cpha[w_rr_idx];
  assign w_sel_bc_ok = bit_count_ok(w_sel_bc);

  assign w_owner_oh  = N_REQ'(1) << r_owner;

  // ---------------------------------------------------------------- FSM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------- FSM next-state / outputs
  always_comb begin
    w_next    = r_state;
    w_gnt     = '0;
    w_rsp_vld = '0;
    w_rsp_dat = '0;
    w_rsp_err = 1'b0;
    w_m_start = 1'b0;
    w_cs_n    = '1;

    case (r_state)
      ST_IDLE: begin
        // A bad length never reaches the master: answer with an error at once.
        if (w_pick) begin
          w_next = w_sel_bc_ok ? ST_LAUNCH : ST_RESPOND;
        end
      end

      ST_LAUNCH: begin
        w_m_start       = 1'b1;
        w_gnt           = w_owner_oh;
        w_cs_n[r_owner] = arb.m_cs;
        w_next          = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        w_gnt           = w_owner_oh;
        w_cs_n[r_owner] = arb.m_cs;
        if (arb.m_done) begin
          w_next = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        // The master's rx word is valid in the cycle after m_done, i.e. here.
        w_rsp_vld = w_owner_oh;
        w_rsp_err = r_err;
        w_rsp_dat = r_err ? '0 : arb.m_rx_data;
        w_next    = (CS_GAP > 0) ? ST_GAP : ST_IDLE;
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_next = ST_IDLE;
        end
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_err     <= 1'b0;
      r_gap_cnt <= '0;
      r_m_tx    <= '0;
      r_m_bc    <= '0;
      r_m_div   <= '0;
      r_m_cpol  <= 1'b0;
      r_m_cpha  <= 1'b0;
    end else begin
      // Command fields are frozen from one pick to the next.
      if (w_pick) begin
        r_owner  <= w_rr_idx;
        r_err    <= !w_sel_bc_ok;
        r_m_tx   <= w_sel_tx;
        r_m_bc   <= w_sel_bc;
        r_m_div  <= w_sel_div;
        r_m_cpol <= w_sel_cpol;
        r_m_cpha <= w_sel_cpha;
      end

      // The just-served requester drops to lowest priority.
      if (r_state == ST_RESPOND) begin
        r_ptr <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
      end

      if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- output drive
  assign arb.gnt         = w_gnt;
  assign arb.rsp_valid   = w_rsp_vld;
  assign arb.rsp_data    = w_rsp_dat;
  assign arb.rsp_err     = w_rsp_err;
  assign arb.m_start     = w_m_start;
  assign arb.m_tx_data   = r_m_tx;
  assign arb.m_bit_count = r_m_bc;
  assign arb.m_clk_div   = r_m_div;
  assign arb.m_cpol      = r_m_cpol;
  assign arb.m_cpha      = r_m_cpha;
  assign arb.cs_n        = w_cs_n;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural SPI master model.
// Latency: model holds busy/cs for three cycles after m_start, then pulses m_done.
// Backpressure: busy can be forced high to stall arbitration.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_arbiter_if #(.N_REQ(N)) arb_if ();

  spi_arbiter #(.N_REQ(N), .CS_GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- SPI master model
  logic        model_busy = 1'b0;
  logic        busy_force = 1'b0;
  logic        start_s    = 1'b0;
  int          model_cnt  = 0;
  logic [31:0] slave_rx   = 32'h0;

  assign arb_if.m_busy = model_busy | busy_force;

  always @(negedge clk) start_s = arb_if.m_start;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      model_busy       = 1'b0;
      model_cnt        = 0;
      arb_if.m_done    = 1'b0;
      arb_if.m_cs      = 1'b1;
      arb_if.m_rx_data = JUNK;
    end else begin
      // Received word is presented only in the cycle after m_done.
      arb_if.m_rx_data = arb_if.m_done ? slave_rx : JUNK;
      arb_if.m_done    = 1'b0;
      if (model_busy) begin
        if (model_cnt == 0) begin
          model_busy    = 1'b0;
          arb_if.m_cs   = 1'b1;
          arb_if.m_done = 1'b1;
        end else begin
          model_cnt--;
        end
      end else if (start_s) begin
        model_busy  = 1'b1;
        arb_if.m_cs = 1'b0;
        model_cnt   = 2;
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  int          n_start = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          cs_bad = 0;
  int          cs_low_cnt [N];
  logic [N-1:0] start_gnt = '0;
  logic [31:0] st_tx = '0;
  logic [5:0]  st_bc = '0;
  logic [15:0] st_div = '0;
  logic        st_cpol = 1'b0;
  logic        st_cpha = 1'b0;
  int          n_rsp = 0;

  initial for (int i = 0; i < N; i++) cs_low_cnt[i] = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (arb_if.m_start) begin
        n_start++;
        start_cyc = cyc;
        start_gnt = arb_if.gnt;
        st_tx     = arb_if.m_tx_data;
        st_bc     = arb_if.m_bit_count;
        st_div    = arb_if.m_clk_div;
        st_cpol   = arb_if.m_cpol;
        st_cpha   = arb_if.m_cpha;
      end
      if (arb_if.m_done) done_cyc = cyc;
      if (|arb_if.rsp_valid) n_rsp++;
      if (!$onehot0(arb_if.gnt)) cs_bad++;
      for (int i = 0; i < N; i++) begin
        if (arb_if.cs_n[i] !== (arb_if.gnt[i] ? arb_if.m_cs : 1'b1)) cs_bad++;
        if (arb_if.cs_n[i] === 1'b0) cs_low_cnt[i]++;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  typedef struct {
    logic [3:0]  req;
    logic [31:0] tx;
    logic [5:0]  bc;
    logic [15:0] div;
    logic        cpol;
    logic        cpha;
    logic [31:0] rx;
    int          win;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];

  // Winner gets the given settings; everyone else gets distinct decoy values.
  task automatic set_cfg(input int win, input logic [31:0] tx, input logic [5:0] bc,
                         input logic [15:0] div, input logic cpol, input logic cpha);
    for (int i = 0; i < N; i++) begin
      if (i == win) begin
        arb_if.req_tx_data[i*32 +: 32]  = tx;
        arb_if.req_bit_count[i*6 +: 6]  = bc;
        arb_if.req_clk_div[i*16 +: 16]  = div;
        arb_if.req_cpol[i]              = cpol;
        arb_if.req_cpha[i]              = cpha;
      end else begin
        arb_if.req_tx_data[i*32 +: 32]  = 32'h5555_0000 | 32'(i);
        arb_if.req_bit_count[i*6 +: 6]  = 6'd16;
        arb_if.req_clk_div[i*16 +: 16]  = 16'h7777;
        arb_if.req_cpol[i]              = ~cpol;
        arb_if.req_cpha[i]              = ~cpha;
      end
    end
  endtask

  task automatic wait_rsp(output bit got, input string name);
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (|arb_if.rsp_valid) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s: got no rsp_valid in 100 cycles, expected a response", name);
    end
  endtask

  task automatic wait_wait_done(input int who, input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (arb_if.gnt[who] && !arb_if.m_start) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int s0;
    int c0;
    bit got;
    @(negedge clk);
    s0 = n_start;
    c0 = cs_low_cnt[v.win];
    slave_rx = v.rx;
    set_cfg(v.win, v.tx, v.bc, v.div, v.cpol, v.cpha);
    arb_if.req = v.req;
    wait_rsp(got, {nm, "_timeout"});
    if (got) begin
      check({nm, "_rsp_valid"}, 64'(arb_if.rsp_valid), 64'(1 << v.win));
      check({nm, "_rsp_data"},  64'(arb_if.rsp_data), 64'(v.data));
      check({nm, "_rsp_err"},   64'(arb_if.rsp_err), 64'(v.err));
      check({nm, "_m_hold"},
            {arb_if.m_tx_data, arb_if.m_bit_count, arb_if.m_clk_div, arb_if.m_cpol, arb_if.m_cpha},
            {v.tx, v.bc, v.div, v.cpol, v.cpha});
      check({nm, "_n_start"}, 64'(n_start - s0), v.err ? 64'd0 : 64'd1);
      if (!v.err) begin
        check({nm, "_m_fields"}, {st_tx, st_bc, st_div, st_cpol, st_cpha},
              {v.tx, v.bc, v.div, v.cpol, v.cpha});
        check({nm, "_start_gnt"}, 64'(start_gnt), 64'(1 << v.win));
        check({nm, "_done_to_rsp"}, 64'(cyc - done_cyc), 64'd1);
        check({nm, "_cs_low"}, 64'(cs_low_cnt[v.win] > c0), 64'd1);
      end
    end
    arb_if.req = '0;
    repeat (GAP + 2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    bit got;
    int c0;
    int prev_rsp;
    int idx;
    int nr0;
    vec_t vr;

    arb_if.req = '0;
    set_cfg(-1, 32'h0, 6'd8, 16'h0, 1'b0, 1'b0);

    vecs[0] = '{req:4'b0100, tx:32'h0000_00A5, bc:6'd8,  div:16'd1, cpol:1'b0, cpha:1'b0,
                rx:32'h0000_003C, win:2, err:1'b0, data:32'h0000_003C};
    vecs[1] = '{req:4'b0010, tx:32'h1111_2222, bc:6'd0,  div:16'd2, cpol:1'b0, cpha:1'b1,
                rx:32'h0BAD_0BAD, win:1, err:1'b1, data:32'h0};
    vecs[2] = '{req:4'b0101, tx:32'hDEAD_BEEF, bc:6'd32, div:16'd3, cpol:1'b1, cpha:1'b1,
                rx:32'h1234_5678, win:2, err:1'b0, data:32'h1234_5678};
    vecs[3] = '{req:4'b0011, tx:32'h0000_0001, bc:6'd1,  div:16'd0, cpol:1'b0, cpha:1'b0,
                rx:32'hFFFF_FFFF, win:0, err:1'b0, data:32'hFFFF_FFFF};
    vecs[4] = '{req:4'b1001, tx:32'hCAFE_F00D, bc:6'd33, div:16'd3, cpol:1'b1, cpha:1'b1,
                rx:32'h7777_7777, win:3, err:1'b1, data:32'h0};
    vecs[5] = '{req:4'b1111, tx:32'h0F0F_0F0F, bc:6'd63, div:16'd0, cpol:1'b0, cpha:1'b0,
                rx:32'h6666_6666, win:0, err:1'b1, data:32'h0};
    vecs[6] = '{req:4'b1100, tx:32'hA5A5_0000, bc:6'd16, div:16'd3, cpol:1'b1, cpha:1'b1,
                rx:32'h0000_A5A5, win:2, err:1'b0, data:32'h0000_A5A5};
    vecs[7] = '{req:4'b0001, tx:32'h8000_0000, bc:6'd31, div:16'd0, cpol:1'b1, cpha:1'b0,
                rx:32'h8000_0001, win:0, err:1'b0, data:32'h8000_0001};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_gnt",     64'(arb_if.gnt), 64'h0);
    check("rst_rsp",     {arb_if.rsp_valid, arb_if.rsp_err, arb_if.rsp_data}, 64'h0);
    check("rst_m_cmd",   {arb_if.m_start, arb_if.m_tx_data, arb_if.m_bit_count,
                          arb_if.m_clk_div, arb_if.m_cpol, arb_if.m_cpha}, 64'h0);
    check("rst_cs_n",    64'(arb_if.cs_n), 64'hF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All four held: order 0,1,2,3,0 with the gap between transactions
    set_cfg(-1, 32'h0, 6'd8, 16'h2, 1'b0, 1'b0);
    slave_rx = 32'h0000_00C0;
    @(negedge clk);
    c0 = cyc;
    arb_if.req = '1;
    prev_rsp = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(got, $sformatf("rr%0d_timeout", k));
      if (!got) break;
      idx = -1;
      for (int i = 0; i < N; i++) if (arb_if.rsp_valid[i]) idx = i;
      check($sformatf("rr%0d_owner", k), 64'(idx), 64'(k % N));
      check($sformatf("rr%0d_tx", k), 64'(st_tx), 64'(32'h5555_0000 | 32'(k % N)));
      check($sformatf("rr%0d_data", k), 64'(arb_if.rsp_data), 64'h0000_00C0);
      if (k == 0) check("rr0_pick_to_start", 64'(start_cyc - c0), 64'd1);
      else        check($sformatf("rr%0d_gap", k), 64'(start_cyc - prev_rsp), 64'(GAP + 2));
      prev_rsp = cyc;
    end
    arb_if.req = '0;
    repeat (GAP + 2) @(negedge clk);

    // Table vectors
    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Busy master stalls arbitration
    @(negedge clk);
    busy_force = 1'b1;
    set_cfg(0, 32'h0000_5A5A, 6'd12, 16'd5, 1'b0, 1'b1);
    slave_rx = 32'h0000_0042;
    c0 = n_start;
    arb_if.req = 4'b0001;
    repeat (6) @(negedge clk);
    check("busy_no_start", 64'(n_start - c0), 64'd0);
    check("busy_no_gnt", 64'(arb_if.gnt), 64'h0);
    busy_force = 1'b0;
    wait_rsp(got, "busy_timeout");
    if (got) begin
      check("busy_rsp_valid", 64'(arb_if.rsp_valid), 64'h1);
      check("busy_rsp_data", 64'(arb_if.rsp_data), 64'h42);
    end
    arb_if.req = '0;
    repeat (GAP + 2) @(negedge clk);

    // Requester 3 drops its request mid-transfer
    set_cfg(3, 32'h3333_0003, 6'd24, 16'd1, 1'b1, 1'b0);
    slave_rx = 32'h5A5A_0303;
    arb_if.req = 4'b1000;
    wait_wait_done(3, "drop_reach_wait");
    arb_if.req = '0;
    wait_rsp(got, "drop_timeout");
    if (got) begin
      check("drop_rsp_valid", 64'(arb_if.rsp_valid), 64'h8);
      check("drop_rsp_data", 64'(arb_if.rsp_data), 64'h5A5A_0303);
    end
    repeat (GAP + 2) @(negedge clk);

    // Reset during WAIT_DONE
    set_cfg(1, 32'h0101_0101, 6'd8, 16'd3, 1'b1, 1'b1);
    slave_rx = 32'h0000_1111;
    arb_if.req = 4'b0010;
    wait_wait_done(1, "mid_rst_reach_wait");
    #1 rst = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(arb_if.gnt), 64'h0);
    check("mid_rst_rsp", {arb_if.rsp_valid, arb_if.rsp_err, arb_if.rsp_data}, 64'h0);
    check("mid_rst_m_cmd", {arb_if.m_start, arb_if.m_tx_data, arb_if.m_bit_count,
                            arb_if.m_clk_div, arb_if.m_cpol, arb_if.m_cpha}, 64'h0);
    check("mid_rst_cs_n", 64'(arb_if.cs_n), 64'hF);
    arb_if.req = '0;
    @(negedge clk);
    rst = 1'b0;
    nr0 = n_rsp;
    repeat (6) @(negedge clk);
    check("mid_rst_no_rsp", 64'(n_rsp - nr0), 64'd0);
    vr = '{req:4'b0001, tx:32'h0000_00F0, bc:6'd8, div:16'd0, cpol:1'b0, cpha:1'b0,
           rx:32'h0000_000F, win:0, err:1'b0, data:32'h0000_000F};
    run_vec("after_rst", vr);

    check("cs_n_protocol", 64'(cs_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4; number of requesters sharing one SPI master, range 2..8.
REQ-002 Parameter CS_GAP, default 2; idle cycles with all chip-selects deasserted between transactions, range 0..15.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req  in  N_REQ  per-requester transaction request, level, held until own rsp_valid.
REQ-006 req_tx_data  in  32*N_REQ  packed per-requester transmit word, slice i = bits [32i+31:32i].
REQ-007 req_bit_count  in  6*N_REQ  packed per-requester transfer length in bits.
REQ-008 req_clk_div  in  16*N_REQ  packed per-requester SCLK divider.
REQ-009 req_cpol, req_cpha  in  N_REQ each  per-requester SPI mode.
REQ-010 gnt  out  N_REQ  one-hot owner indicator, high from launch to completion.
REQ-011 rsp_valid  out  N_REQ  one-cycle completion pulse to the owner.
REQ-012 rsp_data  out  32  received word, valid with any rsp_valid bit.
REQ-013 rsp_err  out  1  request rejected, valid with rsp_valid.
REQ-014 m_start, m_tx_data[32], m_bit_count[6], m_clk_div[16], m_cpol, m_cpha  out  drive SPI master command inputs.
REQ-015 m_busy, m_done, m_cs, m_rx_data[32]  in  SPI master status; m_done is a one-cycle pulse, m_rx_data valid in the cycle after m_done.
REQ-016 cs_n  out  N_REQ  per-device chip-select, active-low.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT_DONE, RESPOND, GAP.
REQ-018 IDLE: when any req bit is high and m_busy=0, round-robin picks a winner and the FSM goes to LAUNCH next cycle; if m_busy=1, it stays in IDLE.
REQ-019 Round-robin: the search starts at ptr and goes upward with wrap; after any response, ptr = owner+1 mod N_REQ.
REQ-020 On the pick edge, the block registers owner and latches the owner's tx_data, bit_count, clk_div, cpol and cpha into the m_* outputs; m_* are stable until the next pick.
REQ-021 Invalid bit_count (0 or >32): the block skips LAUNCH and goes to RESPOND with rsp_err=1, rsp_data=0, and no m_start.
REQ-022 LAUNCH: m_start=1 and gnt[owner]=1 for exactly one cycle, then the FSM goes to WAIT_DONE.
REQ-023 WAIT_DONE: gnt[owner] is held; on m_done=1 the FSM goes to RESPOND.
REQ-024 RESPOND: rsp_valid[owner]=1 and rsp_data=m_rx_data for one cycle; gnt drops; the FSM goes to GAP if CS_GAP>0, otherwise to IDLE.
REQ-025 GAP: a counter counts CS_GAP cycles, then the FSM goes to IDLE; requests are not accepted during GAP.
REQ-026 Pick-to-m_start latency is 1 cycle; m_done-to-rsp_valid latency is 1 cycle.
REQ-027 cs_n[owner] = m_cs in LAUNCH and WAIT_DONE; all other cs_n bits and all bits in other states = 1.
REQ-028 Deassertion of req[owner] after the pick is ignored; the transaction completes and responds.
REQ-029 A requester whose req is still high after its response is re-arbitrated at the lowest priority.

Reset
REQ-030 Reset values: FSM=IDLE, ptr=0, owner=0, gnt=0, rsp_valid=0, rsp_err=0, rsp_data=0, m_start=0, m_* command fields=0, cs_n all 1.
REQ-031 Reset asserted mid-transaction aborts immediately with no response; the SPI master is reset by the same rst.

Structure
REQ-032 Shared package spi_arb_pkg holds the state enum, DATA_W=32, BITCNT_W=6, DIV_W=16 and MAX_BITS=32.
REQ-033 Round-robin selection lives in sub-module spi_rr_arbiter (inputs req and ptr; outputs one-hot grant and index; purely combinational).

Verification
REQ-034 Single transaction: req[2]=1, bit_count=8, tx=0xA5, slave returns 0x3C -> m_start 1 cycle after pick, only cs_n[2] toggles, rsp_valid[2] with rsp_data=0x3C.
REQ-035 All four requests held high continuously -> service order 0,1,2,3,0, with CS_GAP=2 cycles of all-high cs_n between transactions.
REQ-036 bit_count=0 on req[1] -> rsp_valid[1] with rsp_err=1, no m_start, ptr advances to 2.
REQ-037 req[3] drops during WAIT_DONE -> transaction completes and rsp_valid[3] still pulses.
REQ-038 rst pulsed during WAIT_DONE -> all outputs at reset values in the same cycle; next req[0] is served normally.
REQ-039 Per-requester modes (cpol/cpha 0/0 and 1/1, clk_div 0 and 3) alternated -> m_* fields match the owner's settings for every transaction.
